// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD stream writer
package lcd_pkg;

    // Writer sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_SETUP,
        ST_EHI,
        ST_ELO,
        ST_ADV,
        ST_DONE
    } lcd_state_t;

    // Command byte that needs the long hold after it
    localparam logic [7:0] CMD_CLEAR = 8'h3e;
    localparam logic       RS_CMD    = 1'b0;
    localparam logic       RS_DATA   = 1'b1;

    // Default bus timing in clock cycles
    localparam int DEF_T_AS  = 2;
    localparam int DEF_T_EH  = 8;
    localparam int DEF_T_EL  = 8;
    localparam int DEF_T_CLR = 1000;

    // Widths of a ROM item, the ROM length/index and the timing counter
    localparam int ITEM_W = 9;
    localparam int LEN_W  = 10;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/lcd_delay_cnt.sv
// rtl/lcd_delay_cnt.sv - loadable 16-bit down-counter with zero flag
module lcd_delay_cnt
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load takes priority; otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_stream_writer.sv
// rtl/lcd_stream_writer.sv - paces a picture ROM and writes its items onto the LCD bus
module lcd_stream_writer
    import lcd_pkg::*;
#(
    parameter int         T_AS   = DEF_T_AS,
    parameter int         T_EH   = DEF_T_EH,
    parameter int         T_EL   = DEF_T_EL,
    parameter int         T_CLR  = DEF_T_CLR,
    parameter logic [1:0] CS_VAL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ITEM_W-1:0] rom_d_i,
    input  logic [LEN_W-1:0]  rom_length_i,
    output logic              rom_sync_o,
    output logic              rom_en_o,
    output logic [7:0]        lcd_db_o,
    output logic              lcd_rs_o,
    output logic              lcd_rw_o,
    output logic              lcd_e_o,
    output logic [1:0]        lcd_cs_o,
    output logic              busy_o,
    output logic              done_o
);

    // Counter reload values: a state lasting N cycles is entered with N-1
    localparam logic [CNT_W-1:0] AS_LD  = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] EH_LD  = CNT_W'(T_EH - 1);
    localparam logic [CNT_W-1:0] EL_LD  = CNT_W'(T_EL - 1);
    localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(T_CLR - 1);

    lcd_state_t       state_q;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] len_q;
    logic             clr_q;
    logic             rom_sync_q;
    logic             rom_en_q;
    logic [7:0]       db_q;
    logic             rs_q;
    logic             e_q;
    logic [1:0]       cs_q;
    logic             busy_q;
    logic             done_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    lcd_delay_cnt u_delay (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Reload the timer on the cycle that enters each timed state
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_LOAD: begin
                cnt_load = 1'b1;
                cnt_val  = AS_LD;
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = EH_LD;
                end
            end
            ST_EHI: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = clr_q ? CLR_LD : EL_LD;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    // Sequencer; every output is a register set on entry to the state that owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            clr_q      <= 1'b0;
            rom_sync_q <= 1'b0;
            rom_en_q   <= 1'b1;
            db_q       <= '0;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            cs_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rom_sync_q <= 1'b0;
            rom_en_q   <= 1'b1;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_SYNC;
                        rom_sync_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    idx_q   <= '0;
                    len_q   <= rom_length_i;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    db_q    <= rom_d_i[ITEM_W-1:1];
                    rs_q    <= rom_d_i[0];
                    cs_q    <= CS_VAL;
                    clr_q   <= (rom_d_i == {CMD_CLEAR, RS_CMD});
                    state_q <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        e_q     <= 1'b1;
                        state_q <= ST_EHI;
                    end
                end
                ST_EHI: begin
                    if (cnt_zero) begin
                        e_q     <= 1'b0;
                        state_q <= ST_ELO;
                    end
                end
                ST_ELO: begin
                    if (cnt_zero) begin
                        // Compare before incrementing so idx never wraps at len=1023
                        if (idx_q == len_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_ADV;
                            rom_en_q <= 1'b0;
                        end
                    end
                end
                ST_ADV: begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= ST_LOAD;
                end
                ST_DONE: begin
                    cs_q    <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_sync_o = rom_sync_q;
    assign rom_en_o   = rom_en_q;
    assign lcd_db_o   = db_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_e_o    = e_q;
    assign lcd_cs_o   = cs_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_lcd_stream_writer.sv
// tb/tb_lcd_stream_writer.sv - self-checking bench for lcd_stream_writer
module tb_lcd_stream_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- DUT 1: default timing, small stub ROM ----------------
    logic       start1 = 1'b0;
    logic [8:0] rom_d1;
    logic [9:0] len1 = '0;
    logic       sync1, en1, rs1, rw1, e1, busy1, done1;
    logic [7:0] db1;
    logic [1:0] cs1;

    lcd_stream_writer dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .rom_d_i(rom_d1), .rom_length_i(len1),
        .rom_sync_o(sync1), .rom_en_o(en1), .lcd_db_o(db1), .lcd_rs_o(rs1), .lcd_rw_o(rw1),
        .lcd_e_o(e1), .lcd_cs_o(cs1), .busy_o(busy1), .done_o(done1)
    );

    logic [8:0] rom1 [0:3];
    int         rom_idx1 = 0;
    always @(posedge clk) begin
        if (sync1) rom_idx1 <= 0;
        else if (!en1) rom_idx1 <= rom_idx1 + 1;
    end
    assign rom_d1 = (rom_idx1 < 4) ? rom1[rom_idx1[1:0]] : 9'h1ff;

    // ---------------- DUT 2: fast timing, full picture ROM ----------------
    logic       start2 = 1'b0;
    logic [8:0] rom_d2;
    logic [9:0] len2 = '0;
    logic       sync2, en2, rs2, rw2, e2, busy2, done2;
    logic [7:0] db2;
    logic [1:0] cs2;

    lcd_stream_writer #(.T_EH(1), .T_EL(1)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .rom_d_i(rom_d2), .rom_length_i(len2),
        .rom_sync_o(sync2), .rom_en_o(en2), .lcd_db_o(db2), .lcd_rs_o(rs2), .lcd_rw_o(rw2),
        .lcd_e_o(e2), .lcd_cs_o(cs2), .busy_o(busy2), .done_o(done2)
    );

    logic [8:0] rom2 [0:127];
    int         rom_idx2 = 0;
    int         max_idx2 = 0;
    always @(posedge clk) begin
        if (sync2) rom_idx2 <= 0;
        else if (!en2) rom_idx2 <= rom_idx2 + 1;
    end
    always @(negedge clk) if (rom_idx2 > max_idx2) max_idx2 = rom_idx2;
    assign rom_d2 = (rom_idx2 < 128) ? rom2[rom_idx2[6:0]] : 9'h1ff;

    // ---------------- scoreboards and monitors ----------------
    typedef struct {
        logic [7:0] db;
        logic       rs;
        int         width;
        int         gap;    // low cycles until the next rise, -1 for the last item
    } pulse_t;

    pulse_t     exp_q[$];
    pulse_t     cur;
    logic [8:0] exp2_q[$];
    bit         mon_en = 0, mon2_en = 0, have_cur = 0, in_gap = 0;
    int         hi_cnt = 0, gap_cnt = 0;
    int         n_pulse1 = 0, n_enlow1 = 0, n_sync1 = 0, n_done1 = 0;
    int         n_pulse2 = 0, n_enlow2 = 0;
    logic       e1_prev = 0, rs1_prev = 0, e2_prev = 0, rs2_prev = 0;
    logic [7:0] db1_prev = 0, db2_prev = 0;
    logic [1:0] cs1_prev = 0, cs2_prev = 0;

    always @(negedge clk) begin
        chk("rw_tied_low", {rw1, rw2}, 0);
        if (e1 && e1_prev) chk("bus1_stable_e_high", {db1, rs1, cs1}, {db1_prev, rs1_prev, cs1_prev});
        if (mon_en) begin
            if (!en1) n_enlow1++;
            if (sync1) n_sync1++;
            if (done1) n_done1++;
            if (e1 && !e1_prev) begin
                n_pulse1++;
                if (in_gap && have_cur && cur.gap >= 0) chk("e_low_gap", gap_cnt, cur.gap);
                in_gap = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", n_pulse1, 0);
                    have_cur = 0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    chk("pulse_db", db1, cur.db);
                    chk("pulse_rs", rs1, cur.rs);
                    chk("pulse_cs", cs1, 3);
                end
                hi_cnt = 1;
            end else if (e1) begin
                hi_cnt++;
            end else if (e1_prev) begin
                if (have_cur) chk("e_high_width", hi_cnt, cur.width);
                in_gap = 1;
                gap_cnt = 1;
            end else if (in_gap) begin
                gap_cnt++;
            end
        end
        e1_prev = e1; db1_prev = db1; rs1_prev = rs1; cs1_prev = cs1;
    end

    always @(negedge clk) begin
        if (e2 && e2_prev) chk("bus2_stable_e_high", {db2, rs2, cs2}, {db2_prev, rs2_prev, cs2_prev});
        if (mon2_en) begin
            if (!en2) n_enlow2++;
            if (e2 && !e2_prev) begin
                logic [8:0] p;
                n_pulse2++;
                if (exp2_q.size() == 0) begin
                    chk("pic_unexpected_pulse", n_pulse2, 0);
                end else begin
                    p = exp2_q.pop_front();
                    chk("pic_db", db2, p[8:1]);
                    chk("pic_rs", rs2, p[0]);
                end
            end
        end
        e2_prev = e2; db2_prev = db2; rs2_prev = rs2; cs2_prev = cs2;
    end

    // ---------------- vector table ----------------
    typedef struct {
        int         len;
        logic [8:0] it0, it1, it2;
        bit         poke;       // re-pulse start_i while E is high
        int         exp_pulses;
        int         exp_enlow;
        int         exp_done;   // posedges from the start-sampling edge to done_o seen high
    } vec_t;

    vec_t tab [4];

    task automatic run_vec(input vec_t v, input string tag);
        logic [8:0] its [3];
        int lat;
        bit got_done, poked;
        its[0] = v.it0; its[1] = v.it1; its[2] = v.it2;
        rom1[0] = v.it0; rom1[1] = v.it1; rom1[2] = v.it2; rom1[3] = 9'h0aa;
        len1 = 10'(v.len);
        exp_q.delete();
        have_cur = 0; in_gap = 0;
        n_pulse1 = 0; n_enlow1 = 0; n_sync1 = 0; n_done1 = 0;
        for (int i = 0; i <= v.len; i++) begin
            pulse_t p;
            p.db    = its[i][8:1];
            p.rs    = its[i][0];
            p.width = 8;
            p.gap   = (i == v.len) ? -1 : (((its[i] == {8'h3e, 1'b0}) ? 1000 : 8) + 1 + 1 + 2);
            exp_q.push_back(p);
        end
        mon_en = 1;
        start1 = 1'b1;
        lat = 0; got_done = 0; poked = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (v.poke && e1 && !poked) begin
                start1 = 1'b1;
                poked = 1;
            end
            lat++;
            if (done1) begin
                got_done = 1;
                break;
            end
        end
        start1 = 1'b0;
        $display("vector %s", tag);
        chk("done_seen", got_done, 1);
        chk("done_latency", lat, v.exp_done);
        chk("busy_during_done", busy1, 1);
        @(posedge clk); #1;
        chk("done_one_cycle", done1, 0);
        chk("busy_falls", busy1, 0);
        chk("cs_released", cs1, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("pulse_count", n_pulse1, v.exp_pulses);
        chk("rom_en_low_cycles", n_enlow1, v.exp_enlow);
        chk("rom_sync_cycles", n_sync1, 1);
        chk("done_pulses", n_done1, 1);
        chk("rom_index_end", rom_idx1, v.len);
        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rises;
        logic ep;
        bit hit;

        tab[0] = '{len: 2, it0: {8'h3e, 1'b0}, it1: {8'hb9, 1'b0}, it2: {8'h55, 1'b1},
                   poke: 0, exp_pulses: 3, exp_enlow: 2, exp_done: 1053};
        tab[1] = '{len: 0, it0: {8'h3f, 1'b0}, it1: 9'h000, it2: 9'h000,
                   poke: 0, exp_pulses: 1, exp_enlow: 0, exp_done: 21};
        tab[2] = '{len: 2, it0: {8'h3e, 1'b0}, it1: {8'hb9, 1'b0}, it2: {8'h55, 1'b1},
                   poke: 1, exp_pulses: 3, exp_enlow: 2, exp_done: 1053};
        tab[3] = '{len: 1, it0: {8'h55, 1'b1}, it1: {8'h3e, 1'b0}, it2: {8'h12, 1'b1},
                   poke: 0, exp_pulses: 2, exp_enlow: 1, exp_done: 1033};

        for (int i = 0; i < 128; i++) begin
            if (i == 0) rom2[i] = {8'h3f, 1'b0};
            else if (i % 9 == 2) rom2[i] = {8'hb8 + 8'(i / 9), 1'b0};
            else rom2[i] = {8'(i * 37 + 5), 1'b1};
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_sync", sync1, 0);
        chk("rst_rom_en", en1, 1);
        chk("rst_db", db1, 0);
        chk("rst_rs", rs1, 0);
        chk("rst_e", e1, 0);
        chk("rst_cs", cs1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_start_busy", busy1, 0);

        for (int i = 0; i < 4; i++) run_vec(tab[i], $sformatf("%0d", i));

        // Reset in the middle of the second E pulse, then redraw
        rom1[0] = tab[0].it0; rom1[1] = tab[0].it1; rom1[2] = tab[0].it2;
        len1 = 10'd2;
        mon_en = 0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        rises = 0; ep = 0; hit = 0;
        for (int c = 0; c < 3000; c++) begin
            if (e1 && !ep) rises++;
            ep = e1;
            if (rises == 2) begin
                hit = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reached_second_pulse", hit, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_e", e1, 0);
        chk("midrst_rom_en", en1, 1);
        chk("midrst_busy", busy1, 0);
        chk("midrst_db", db1, 0);
        chk("midrst_cs", cs1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_resume", e1 | busy1, 0);
        run_vec(tab[0], "redraw");

        // Real picture on the fast-timing instance
        len2 = 10'd83;
        exp2_q.delete();
        for (int i = 0; i <= 83; i++) exp2_q.push_back(rom2[i]);
        n_pulse2 = 0; n_enlow2 = 0;
        mon2_en = 1;
        start2 = 1'b1;
        hit = 0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (done2) begin
                hit = 1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("pic_done_seen", hit, 1);
        chk("pic_pulse_count", n_pulse2, 84);
        chk("pic_rom_en_low", n_enlow2, 83);
        chk("pic_rom_index_end", rom_idx2, 83);
        chk("pic_rom_no_overrun", max_idx2, 83);
        chk("pic_scoreboard_drained", exp2_q.size(), 0);
        chk("pic_busy_falls", busy2, 0);
        mon2_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
